// File: rtl/quad_cnt_pkg.sv
// quad_cnt_pkg: shared types, BCD limits and load sanitising for the quad BCD counter
// Contents: bcd_digit_t, run_state_t, BCD_MAX/BCD_MIN, bcd_sanitize()
package quad_cnt_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic {STOPPED, RUNNING} run_state_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t n);
        return (n > BCD_MAX) ? BCD_MIN : n;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with clear, load and up/down step
// Ports: clk, rst (sync, active-high), clr, load, load_digit (already sanitised),
//        step (count this cycle), dn (1 = decrement), digit (registered value),
//        carry (combinational carry/borrow into the next digit)
module bcd_digit
    import quad_cnt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       load,
    input  bcd_digit_t load_digit,
    input  logic       step,
    input  logic       dn,
    output bcd_digit_t digit,
    output logic       carry
);

    assign carry = step && (dn ? digit == BCD_MIN : digit == BCD_MAX);

    always_ff @(posedge clk) begin
        if (rst || clr)
            digit <= BCD_MIN;
        else if (load)
            digit <= load_digit;
        else if (step)
            digit <= dn ? ((digit == BCD_MIN) ? BCD_MAX : digit - 4'd1)
                        : ((digit == BCD_MAX) ? BCD_MIN : digit + 4'd1);
    end

endmodule

// File: rtl/quad_bcd_counter.sv
// quad_bcd_counter: NUM_DIGITS-digit packed-BCD counter with run/stop FSM, clear, load and wrap
// Ports: clk, rst (sync, active-high), en (count tick), start/stop (run control pulses),
//        clr, load, load_val (packed BCD, digit 0 in [3:0]), count (registered BCD),
//        running, wrap (roll-over pulse), load_err (invalid nibble pulse)
// Optional: QUAD_CNT_UPDOWN_EN adds input dn; dn=1 makes each counted tick decrement.
module quad_bcd_counter
    import quad_cnt_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clr,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
`ifdef QUAD_CNT_UPDOWN_EN
    input  logic                    dn,
`endif
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    wrap,
    output logic                    load_err
);

    logic                  down;
    run_state_t            state;
    logic [NUM_DIGITS:0]   step;
    logic [NUM_DIGITS-1:0] bad;

`ifdef QUAD_CNT_UPDOWN_EN
    assign down = dn;
`else
    assign down = 1'b0;
`endif

    // Uses the pre-edge state, so a start never counts the same-cycle tick
    // while a stop still lets it through; clr and load swallow the tick.
    assign step[0] = en && state == RUNNING && !clr && !load;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_t ld;
        assign ld     = bcd_sanitize(load_val[4*i +: 4]);
        assign bad[i] = load_val[4*i +: 4] > BCD_MAX;
        bcd_digit u_digit (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .load       (load),
            .load_digit (ld),
            .step       (step[i]),
            .dn         (down),
            .digit      (count[4*i +: 4]),
            .carry      (step[i+1])
        );
    end

    // Carry out of the top digit only happens on all-9s up or all-0s down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= STOPPED;
            running  <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= stop ? STOPPED : start ? RUNNING : state;
            running  <= !stop && (start || state == RUNNING);
            wrap     <= step[NUM_DIGITS];
            load_err <= load && !clr && |bad;
        end
    end

endmodule

// File: tb/tb_quad_bcd_counter.sv
// tb_quad_bcd_counter: directed and random checks of quad_bcd_counter against a decimal model
module tb_quad_bcd_counter;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b0, en = 1'b0, start = 1'b0, stop = 1'b0, clr = 1'b0, load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         dn = 1'b0;
    logic [W-1:0] count;
    logic         running, wrap, load_err;

    int vectors = 0;
    int miscompares = 0;

    int m_cnt = 0;
    bit m_run = 0, m_wrap = 0, m_lerr = 0;

    always #10 clk = ~clk;

    quad_bcd_counter #(.NUM_DIGITS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
`ifdef QUAD_CNT_UPDOWN_EN
        .dn       (dn),
`endif
        .count    (count),
        .running  (running),
        .wrap     (wrap),
        .load_err (load_err)
    );

    function automatic int modulus();
        int m = 1;
        for (int i = 0; i < N; i++) m *= 10;
        return m;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] b = '0;
        for (int i = 0; i < N; i++) begin
            b[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p, input bit e,
                       input bit c, input bit l, input logic [W-1:0] lv, input bit d);
        int  mod = modulus();
        int  lvl, scale;
        bit  dd, any_bad, inc;
        @(negedge clk);
        rst = r; start = s; stop = p; en = e; clr = c; load = l; load_val = lv; dn = d;
        @(posedge clk);
        #1;
`ifdef QUAD_CNT_UPDOWN_EN
        dd = d;
`else
        dd = 0;
`endif
        if (r) begin
            m_cnt = 0; m_run = 0; m_wrap = 0; m_lerr = 0;
        end else begin
            inc = e && m_run;
            m_run = p ? 0 : s ? 1 : m_run;
            m_wrap = 0;
            m_lerr = 0;
            if (c) begin
                m_cnt = 0;
            end else if (l) begin
                lvl = 0; scale = 1; any_bad = 0;
                for (int i = 0; i < N; i++) begin
                    if (lv[4*i +: 4] > 9) any_bad = 1;
                    else lvl += int'(lv[4*i +: 4]) * scale;
                    scale *= 10;
                end
                m_cnt = lvl;
                m_lerr = any_bad;
            end else if (inc) begin
                m_wrap = dd ? (m_cnt == 0) : (m_cnt == mod - 1);
                m_cnt = dd ? (m_cnt + mod - 1) % mod : (m_cnt + 1) % mod;
            end
        end
        chk("count", 32'(count), 32'(to_bcd(m_cnt)));
        chk("running", 32'(running), 32'(m_run));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("load_err", 32'(load_err), 32'(m_lerr));
    endtask

    initial begin
        logic [W-1:0] rv;
        // reset dominates start and en
        cyc(1, 1, 0, 1, 0, 0, '0, 0);
        cyc(1, 1, 0, 1, 0, 0, '0, 0);
        // ticks while stopped are ignored
        repeat (3) cyc(0, 0, 0, 1, 0, 0, '0, 0);
        // start with a same-cycle tick: tick not counted
        cyc(0, 1, 0, 1, 0, 0, '0, 0);
        repeat (10) cyc(0, 0, 0, 1, 0, 0, '0, 0);
        // cascade through three digits
        cyc(0, 0, 0, 0, 0, 1, 16'h0999, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 0);
        // roll-over from all 9s, then normal count
        cyc(0, 0, 0, 0, 0, 1, 16'h9999, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 0);
        // priority cases
        cyc(0, 0, 0, 1, 1, 1, 16'h5555, 0);
        cyc(0, 0, 0, 1, 0, 1, 16'h1234, 0);
        cyc(0, 0, 1, 0, 0, 0, '0, 0);
        cyc(0, 1, 1, 0, 0, 0, '0, 0);
        cyc(0, 1, 0, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 0, 0, 1, 16'h0005, 0);
        cyc(0, 0, 1, 1, 0, 0, '0, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 0);
        // invalid nibbles are zeroed and flagged
        cyc(0, 0, 0, 0, 0, 1, 16'hA5F3, 0);
        cyc(0, 0, 0, 0, 0, 0, '0, 0);
        cyc(0, 0, 0, 0, 0, 1, 16'h0042, 0);
`ifdef QUAD_CNT_UPDOWN_EN
        cyc(0, 1, 0, 0, 1, 0, '0, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 1);
        cyc(0, 0, 0, 0, 0, 1, 16'h1000, 0);
        cyc(0, 0, 0, 1, 0, 0, '0, 1);
`endif
        // random traffic
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < N; i++) rv[4*i +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 15) == 0) rv = {N{4'h9}};
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0,
                rv, $urandom_range(0, 1) == 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
